// File: rtl/crc_store_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_store_arbiter_pkg
// Description : Shared definitions for the CRC store arbiter: NIOS bus
//               widths, arbiter state encodings and default lock timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_store_arbiter_pkg;

  // NIOS Avalon-MM word address and data widths
  localparam int CRC_NIOS_ADDR_WIDTH = 27;
  localparam int CRC_NIOS_DATA_WIDTH = 32;

  // Default number of HOLD cycles before a stuck lock is forced free
  localparam int CRC_LOCK_TIMEOUT_DEFAULT = 16;

  // Arbiter states; the spare encoding 2'b11 falls back to IDLE
  typedef enum logic [1:0] {
    CRC_ARB_IDLE  = 2'b00,
    CRC_ARB_GRANT = 2'b01,
    CRC_ARB_HOLD  = 2'b10
  } crc_arb_state_t;

endpackage : crc_store_arbiter_pkg
`default_nettype wire

// File: rtl/crc_store_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : crc_store_arbiter_rr_picker
// Description : Combinational round-robin first-one picker. Scans the
//               request vector upward from rr_ptr with wrap-around and
//               reports the first set position.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_store_arbiter_rr_picker
  import crc_store_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic                 valid,
  output logic [IDX_WIDTH-1:0] index
);

  // Walk from the farthest position back to rr_ptr so the nearest hit wins
  always_comb begin
    int                   pos;
    logic [IDX_WIDTH-1:0] pos_idx;
    valid   = 1'b0;
    index   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos     = (int'(rr_ptr) + k) % NUM_REQ;
      pos_idx = IDX_WIDTH'(pos);
      if (req[pos_idx]) begin
        valid = 1'b1;
        index = pos_idx;
      end
    end
  end

endmodule : crc_store_arbiter_rr_picker
`default_nettype wire

// File: rtl/crc_store_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : crc_store_arbiter
// Description : Round-robin arbiter sharing one Avalon-MM write master among
//               NUM_REQ store buffers. A requester may lock its grant across
//               beats so two-beat fingerprint commits are never interleaved.
//               Optional macro CRC_ARB_TIMEOUT_EN adds a HOLD timeout that
//               forcibly releases a lock and pulses lock_timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_store_arbiter
  import crc_store_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDX_WIDTH    = 2,
  parameter int ADDR_WIDTH   = CRC_NIOS_ADDR_WIDTH,
  parameter int DATA_WIDTH   = CRC_NIOS_DATA_WIDTH,
  parameter int LOCK_TIMEOUT = CRC_LOCK_TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_writedata,
  output logic [NUM_REQ-1:0]           req_waitrequest,
  output logic [ADDR_WIDTH-1:0]        master_address,
  output logic                         master_write,
  output logic [DATA_WIDTH-1:0]        master_writedata,
  input  logic                         master_waitrequest,
  output logic [IDX_WIDTH-1:0]         grant_id,
  output logic                         busy,
  output logic                         lock_timeout
);

  localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(NUM_REQ - 1);

  crc_arb_state_t       r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0] r_grant_id, w_grant_nxt;
  logic [IDX_WIDTH-1:0] r_rr_ptr, w_rr_nxt;
  logic [IDX_WIDTH-1:0] w_ptr_adv;
  logic [IDX_WIDTH-1:0] w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_write_sel;
  logic                 w_lock_sel;
  logic                 w_in_grant;
  logic                 w_beat_done;

  logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

`ifdef CRC_ARB_TIMEOUT_EN
  localparam logic [7:0] c_timeout_last = 8'(LOCK_TIMEOUT - 1);
  logic [7:0] r_hold_cnt, w_hold_cnt_nxt;
  logic       w_timeout_hit;
`endif

  // Split the packed request buses into per-requester words
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_arr[g] = req_writedata[g*DATA_WIDTH +: DATA_WIDTH];
    // Only the requester in GRANT may see its beat accepted
    assign req_waitrequest[g] =
      !(w_in_grant && (r_grant_id == IDX_WIDTH'(g))) || master_waitrequest;
  end

  crc_store_arbiter_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_picker (
    .req    (req_write),
    .rr_ptr (r_rr_ptr),
    .valid  (w_pick_valid),
    .index  (w_pick_idx)
  );

  assign w_in_grant       = (r_state == CRC_ARB_GRANT);
  assign w_write_sel      = req_write[r_grant_id];
  assign w_lock_sel       = req_lock[r_grant_id];
  assign w_ptr_adv        = (r_grant_id == c_last_idx) ? '0 : r_grant_id + 1'b1;
  assign master_write     = w_in_grant && w_write_sel;
  assign w_beat_done      = master_write && !master_waitrequest;
  assign master_address   = w_addr_arr[r_grant_id];
  assign master_writedata = w_data_arr[r_grant_id];
  assign grant_id         = r_grant_id;
  assign busy             = (r_state != CRC_ARB_IDLE);

`ifdef CRC_ARB_TIMEOUT_EN
  assign lock_timeout = w_timeout_hit;
`else
  assign lock_timeout = 1'b0;
`endif

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CRC_ARB_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
`ifdef CRC_ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_rr_ptr   <= w_rr_nxt;
`ifdef CRC_ARB_TIMEOUT_EN
      r_hold_cnt <= w_hold_cnt_nxt;
`endif
    end
  end

  // Next-state logic; every release path hands priority to the next index
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_rr_nxt    = r_rr_ptr;
`ifdef CRC_ARB_TIMEOUT_EN
    w_hold_cnt_nxt = r_hold_cnt;
    w_timeout_hit  = 1'b0;
`endif
    case (r_state)
      CRC_ARB_IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = CRC_ARB_GRANT;
        end
      end
      CRC_ARB_GRANT: begin
        if (w_beat_done) begin
          if (w_lock_sel) begin
            w_state_nxt = CRC_ARB_HOLD;
`ifdef CRC_ARB_TIMEOUT_EN
            w_hold_cnt_nxt = '0;
`endif
          end else begin
            w_state_nxt = CRC_ARB_IDLE;
            w_rr_nxt    = w_ptr_adv;
          end
        end else if (!w_write_sel) begin
          // Requester abandoned its beat; release rather than stall the bus
          w_state_nxt = CRC_ARB_IDLE;
          w_rr_nxt    = w_ptr_adv;
        end
      end
      CRC_ARB_HOLD: begin
        if (w_write_sel) begin
          w_state_nxt = CRC_ARB_GRANT;
        end else if (!w_lock_sel) begin
          w_state_nxt = CRC_ARB_IDLE;
          w_rr_nxt    = w_ptr_adv;
        end else begin
`ifdef CRC_ARB_TIMEOUT_EN
          if (r_hold_cnt == c_timeout_last) begin
            w_state_nxt   = CRC_ARB_IDLE;
            w_rr_nxt      = w_ptr_adv;
            w_timeout_hit = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
          end
`endif
        end
      end
      default: begin
        w_state_nxt = CRC_ARB_IDLE;
      end
    endcase
  end

endmodule : crc_store_arbiter
`default_nettype wire

// File: tb/tb_crc_store_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_store_arbiter
// Description : Self-checking bench for crc_store_arbiter. A transaction-level
//               model predicts the outputs every cycle; directed sequences
//               add literal expectations. Honours CRC_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_store_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int LT = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_write = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N*AW-1:0] req_address = '0;
  logic [N*DW-1:0] req_writedata = '0;
  logic            master_waitrequest = 1'b0;
  logic [N-1:0]    req_waitrequest;
  logic [AW-1:0]   master_address;
  logic            master_write;
  logic [DW-1:0]   master_writedata;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            lock_timeout;

  crc_store_arbiter #(
    .NUM_REQ(N), .IDX_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_write(req_write), .req_lock(req_lock),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_waitrequest(req_waitrequest),
    .master_address(master_address), .master_write(master_write),
    .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
    .grant_id(grant_id), .busy(busy), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_active: owner's write beat is on the bus; m_held: owner keeps the bus
  bit m_active = 1'b0;
  bit m_held   = 1'b0;
  int m_owner  = 0;
  int m_ptr    = 0;
  int m_hold   = 0;   // HOLD cycles already spent waiting

  always @(posedge clk or posedge reset) begin : model
    bit a, h;
    int o, p, hc;
    if (reset) begin
      m_active <= 1'b0; m_held <= 1'b0; m_owner <= 0; m_ptr <= 0; m_hold <= 0;
    end else begin
      a = m_active; h = m_held; o = m_owner; p = m_ptr; hc = m_hold;
      if (!a && !h) begin
        for (int k = 0; k < N; k++) begin
          if (req_write[(p + k) % N]) begin
            o = (p + k) % N;
            a = 1'b1;
            break;
          end
        end
      end else if (a) begin
        if (req_write[o] && !master_waitrequest) begin
          a = 1'b0;
          if (req_lock[o]) begin h = 1'b1; hc = 0; end
          else p = (o + 1) % N;
        end else if (!req_write[o]) begin
          a = 1'b0;
          p = (o + 1) % N;
        end
      end else begin
        if (req_write[o]) begin
          h = 1'b0; a = 1'b1;
        end else if (!req_lock[o]) begin
          h = 1'b0; p = (o + 1) % N;
        end else begin
          hc++;
`ifdef CRC_ARB_TIMEOUT_EN
          if (hc == LT) begin h = 1'b0; p = (o + 1) % N; end
`endif
        end
      end
      m_active <= a; m_held <= h; m_owner <= o; m_ptr <= p; m_hold <= hc;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin : compare
    bit           exp_mw;
    bit           exp_lt;
    logic [N-1:0] exp_wait;
    exp_mw = m_active && req_write[m_owner];
    exp_lt = 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
    exp_lt = m_held && !req_write[m_owner] && req_lock[m_owner] && (m_hold + 1 == LT);
`endif
    for (int i = 0; i < N; i++)
      exp_wait[i] = !(m_active && m_owner == i) || master_waitrequest;
    chk("model_master_write", master_write, exp_mw);
    chk("model_busy", busy, m_active || m_held);
    chk("model_grant_id", grant_id, m_owner);
    chk("model_req_waitrequest", req_waitrequest, exp_wait);
    chk("model_lock_timeout", lock_timeout, exp_lt);
    if (exp_mw) begin
      chk("model_master_address", master_address, req_address[m_owner*AW +: AW]);
      chk("model_master_writedata", master_writedata, req_writedata[m_owner*DW +: DW]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_address[i*AW +: AW]   = a;
    req_writedata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    at_neg();
    cyc();
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1);
  end

  initial begin : stim
    int pulses, pulse_at, first2;

    // Reset values
    set_req(0, 27'h123, 32'h0);
    at_neg();
    chk("rst_master_write", master_write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_lock_timeout", lock_timeout, 1'b0);
    chk("rst_waitrequest", req_waitrequest, 4'hF);
    chk("rst_master_address", master_address, 27'h123);
    cyc();
    reset = 1'b0;

    // Single write from requester 0, no stall
    set_req(0, 27'h40, 32'hDEADBEEF);
    req_write = 4'b0001;
    at_neg(); chk("t1_idle_busy", busy, 1'b0);
    cyc();
    at_neg();
    chk("t1_master_write", master_write, 1'b1);
    chk("t1_address", master_address, 27'h40);
    chk("t1_data", master_writedata, 32'hDEADBEEF);
    chk("t1_waitrequest", req_waitrequest, 4'b1110);
    cyc(); req_write = 4'b0000;
    at_neg(); chk("t1_busy_done", busy, 1'b0);

    // Requesters 1 and 3 together after reset
    do_reset();
    set_req(1, 27'h101, 32'h11111111);
    set_req(3, 27'h303, 32'h33333333);
    set_req(0, 27'h000, 32'h00000000);
    set_req(2, 27'h202, 32'h22222222);
    req_write = 4'b1010;
    at_neg(); cyc();
    at_neg(); chk("t2_first_grant", grant_id, 2'd1); chk("t2_first_write", master_write, 1'b1);
    cyc(); req_write[1] = 1'b0;
    at_neg(); chk("t2_gap_busy", busy, 1'b0);
    cyc();
    at_neg(); chk("t2_second_grant", grant_id, 2'd3); chk("t2_second_addr", master_address, 27'h303);
    cyc(); req_write = 4'b0101;
    at_neg(); cyc();
    at_neg(); chk("t2_wrap_grant", grant_id, 2'd0);
    cyc(); req_write[0] = 1'b0;
    at_neg(); cyc();
    at_neg(); chk("t2_next_grant", grant_id, 2'd2);
    cyc(); req_write = 4'b0000;

    // Locked two-beat write from requester 2 while requester 0 waits
    set_req(2, 27'h10, 32'h00000ABC);
    req_write = 4'b0100; req_lock = 4'b0100;
    at_neg(); cyc();
    set_req(0, 27'h20, 32'h0BADF00D);
    req_write = 4'b0101;
    at_neg();
    chk("t3_b1_grant", grant_id, 2'd2);
    chk("t3_b1_data", master_writedata, 32'h00000ABC);
    chk("t3_b1_wait", req_waitrequest, 4'b1011);
    cyc();
    set_req(2, 27'h11, 32'h12340002);
    req_lock = 4'b0000;
    at_neg();
    chk("t3_hold_busy", busy, 1'b1);
    chk("t3_hold_write", master_write, 1'b0);
    chk("t3_hold_wait", req_waitrequest, 4'hF);
    cyc();
    at_neg();
    chk("t3_b2_grant", grant_id, 2'd2);
    chk("t3_b2_write", master_write, 1'b1);
    chk("t3_b2_data", master_writedata, 32'h12340002);
    chk("t3_b2_addr", master_address, 27'h11);
    cyc(); req_write = 4'b0001;
    at_neg(); chk("t3_idle_busy", busy, 1'b0);
    cyc();
    at_neg(); chk("t3_waiter_grant", grant_id, 2'd0); chk("t3_waiter_write", master_write, 1'b1);
    cyc(); req_write = 4'b0000;

    // Downstream stall held 5 cycles
    master_waitrequest = 1'b1;
    set_req(1, 27'h55, 32'hCAFEF00D);
    req_write = 4'b0010;
    at_neg(); cyc();
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("t4_stall_write", master_write, 1'b1);
      chk("t4_stall_addr", master_address, 27'h55);
      chk("t4_stall_data", master_writedata, 32'hCAFEF00D);
      chk("t4_stall_wait", req_waitrequest, 4'hF);
      cyc();
    end
    master_waitrequest = 1'b0;
    at_neg(); chk("t4_release_wait", req_waitrequest, 4'b1101);
    cyc(); req_write = 4'b0000;

    // Lock held with no second beat; requester 2 waiting
    do_reset();
    set_req(1, 27'h60, 32'h00000001);
    set_req(2, 27'h70, 32'h00000002);
    req_write = 4'b0110; req_lock = 4'b0010;
    at_neg(); cyc();
    at_neg(); chk("t5_grant1", grant_id, 2'd1); chk("t5_grant1_write", master_write, 1'b1);
    cyc(); req_write = 4'b0100;
    pulses = 0; pulse_at = -1; first2 = -1;
    for (int i = 0; i < 20; i++) begin
      at_neg();
      if (lock_timeout === 1'b1) begin pulses++; pulse_at = i; end
      if (master_write === 1'b1 && grant_id === 2'd2 && first2 < 0) first2 = i;
      cyc();
    end
`ifdef CRC_ARB_TIMEOUT_EN
    chk("t5_pulse_count", pulses, 1);
    chk("t5_pulse_cycle", pulse_at, 15);
    chk("t5_waiter_cycle", first2, 17);
    req_write = 4'b0000; req_lock = 4'b0000;
`else
    chk("t5_no_pulse", pulses, 0);
    chk("t5_no_waiter", first2, -1);
    req_lock = 4'b0000;
    at_neg(); chk("t5_still_held", busy, 1'b1);
    cyc();
    at_neg(); chk("t5_released", busy, 1'b0);
    cyc();
    at_neg(); chk("t5_waiter_grant", grant_id, 2'd2); chk("t5_waiter_write", master_write, 1'b1);
    cyc(); req_write = 4'b0000;
`endif
    cyc();

    // Reset in the middle of a stalled GRANT
    master_waitrequest = 1'b1;
    set_req(3, 27'h77, 32'h77777777);
    req_write = 4'b1000;
    at_neg(); cyc();
    at_neg(); chk("t6_pre_write", master_write, 1'b1); chk("t6_pre_grant", grant_id, 2'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_write", master_write, 1'b0);
    chk("t6_rst_grant", grant_id, 2'd0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_wait", req_waitrequest, 4'hF);
    @(posedge clk); #1;
    reset = 1'b0;
    master_waitrequest = 1'b0;
    at_neg(); chk("t6_idle_busy", busy, 1'b0); chk("t6_idle_write", master_write, 1'b0);
    cyc();
    at_neg(); chk("t6_retry_grant", grant_id, 2'd3); chk("t6_retry_write", master_write, 1'b1);
    cyc(); req_write = 4'b0000;
    cyc();
    at_neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_crc_store_arbiter
`default_nettype wire
